// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and helpers for the forwarding/hazard unit
package fwd_pkg;
    localparam int SRC_REGFILE = 0;
    localparam int SB_DST_W = 5;
    typedef struct packed {
        logic                valid;
        logic                wr;
        logic [SB_DST_W-1:0] dst;
        logic                load;
    } sb_entry_t;
    function automatic int sel_width(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction
endpackage

// File: rtl/fwd_operand_select.sv
// fwd_operand_select: youngest-producer priority encoder and load-use hazard for one operand
module fwd_operand_select
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = SB_DST_W,
    parameter int NUM_FWD = 3,
    parameter int SEL_W = sel_width(NUM_FWD),
    parameter int LOAD_READY = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  sb_entry_t [NUM_FWD-1:0] sb,
    input  logic                    id_valid,
    input  logic [REG_ADDR_W-1:0]   r,
    input  logic                    uses,
    output logic [SEL_W-1:0]        sel,
    output logic                    hazard
);
    always_comb begin
        sel = SEL_W'(SRC_REGFILE);
        hazard = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (sb[i].valid && sb[i].wr && sb[i].dst == r && uses && id_valid && !(ZERO_REG && r == '0)) begin
                sel = SEL_W'(i + 1);
                hazard = sb[i].load && (i + 1 < LOAD_READY);
            end
        end
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: scoreboard-based EX operand forwarding selects and load-use stall
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = SB_DST_W,
    parameter int NUM_FWD = 3,
    parameter int SEL_W = sel_width(NUM_FWD),
    parameter int LOAD_READY = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic                  stall,
    output logic [SEL_W-1:0]      ex_sel_rs,
    output logic [SEL_W-1:0]      ex_sel_rt,
    output logic [CNT_W-1:0]      stall_count
);
    sb_entry_t [NUM_FWD-1:0] sb;
    logic [SEL_W-1:0] cand_rs, cand_rt;
    logic haz_rs, haz_rt, bubble;
    fwd_operand_select #(
        .REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W),
        .LOAD_READY(LOAD_READY), .ZERO_REG(ZERO_REG)
    ) u_rs (
        .sb(sb), .id_valid(id_valid), .r(id_rs), .uses(id_uses_rs), .sel(cand_rs), .hazard(haz_rs)
    );
    fwd_operand_select #(
        .REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W),
        .LOAD_READY(LOAD_READY), .ZERO_REG(ZERO_REG)
    ) u_rt (
        .sb(sb), .id_valid(id_valid), .r(id_rt), .uses(id_uses_rt), .sel(cand_rt), .hazard(haz_rt)
    );
    assign stall = (haz_rs | haz_rt) & ~flush;
    assign bubble = flush | stall;
    always_ff @(posedge clock) begin
        if (reset) begin
            sb <= '0;
            ex_sel_rs <= '0;
            ex_sel_rt <= '0;
            stall_count <= '0;
        end else begin
            for (int i = NUM_FWD - 1; i > 0; i--) sb[i] <= sb[i-1];
            sb[0] <= bubble ? '0 : sb_entry_t'{id_valid, id_reg_write, id_dst, id_mem_read};
            ex_sel_rs <= bubble ? '0 : cand_rs;
            ex_sel_rt <= bubble ? '0 : cand_rt;
            if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;
    logic clock = 0, reset = 0;
    logic id_valid = 0, id_uses_rs = 0, id_uses_rt = 0, id_reg_write = 0, id_mem_read = 0, flush = 0;
    logic [4:0] id_rs = 0, id_rt = 0, id_dst = 0;
    logic stall;
    logic [1:0] ex_sel_rs, ex_sel_rt;
    logic [7:0] stall_count;
    int tests = 0, fails = 0;

    fwd_hazard_unit #(.CNT_W(8)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .stall(stall), .ex_sel_rs(ex_sel_rs), .ex_sel_rt(ex_sel_rt), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic [4:0] dst, input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dst = dst; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic do_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        flush = 0;
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %0b exp 0", stall); end
        tests++; if (ex_sel_rs !== 2'd0) begin fails++; $display("FAIL reset_sel_rs got %0d exp 0", ex_sel_rs); end
        tests++; if (ex_sel_rt !== 2'd0) begin fails++; $display("FAIL reset_sel_rt got %0d exp 0", ex_sel_rt); end
        tests++; if (stall_count !== 8'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", stall_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_id(1, 1, 2, 1, 1, 3, 1, 0);
        step();
        set_id(1, 3, 4, 1, 1, 6, 1, 0);
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL b2b_stall got %0b exp 0", stall); end
        step();
        tests++; if (ex_sel_rs !== 2'd1) begin fails++; $display("FAIL b2b_sel_rs got %0d exp 1", ex_sel_rs); end
        tests++; if (ex_sel_rt !== 2'd0) begin fails++; $display("FAIL b2b_sel_rt got %0d exp 0", ex_sel_rt); end
        set_id(1, 3, 3, 1, 1, 7, 1, 0);
        step();
        tests++; if (ex_sel_rs !== 2'd2) begin fails++; $display("FAIL b2b_dist2_rs got %0d exp 2", ex_sel_rs); end
        tests++; if (ex_sel_rt !== 2'd2) begin fails++; $display("FAIL b2b_dist2_rt got %0d exp 2", ex_sel_rt); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 1, 0, 1, 0, 5, 1, 1);
        step();
        set_id(1, 1, 5, 1, 1, 7, 1, 0);
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall got %0b exp 1", stall); end
        step();
        tests++; if (ex_sel_rt !== 2'd0) begin fails++; $display("FAIL lu_bubble_rt got %0d exp 0", ex_sel_rt); end
        tests++; if (stall_count !== 8'd1) begin fails++; $display("FAIL lu_count got %0d exp 1", stall_count); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_stall_end got %0b exp 0", stall); end
        step();
        tests++; if (ex_sel_rt !== 2'd2) begin fails++; $display("FAIL lu_sel_rt got %0d exp 2", ex_sel_rt); end
        tests++; if (ex_sel_rs !== 2'd0) begin fails++; $display("FAIL lu_sel_rs got %0d exp 0", ex_sel_rs); end
        tests++; if (stall_count !== 8'd1) begin fails++; $display("FAIL lu_count_hold got %0d exp 1", stall_count); end
    endtask

    task automatic test_double_producer();
        do_reset();
        set_id(1, 1, 0, 1, 0, 4, 1, 0);
        step();
        set_id(1, 2, 0, 1, 0, 4, 1, 0);
        step();
        set_id(1, 4, 0, 1, 0, 9, 1, 0);
        step();
        tests++; if (ex_sel_rs !== 2'd1) begin fails++; $display("FAIL dbl_sel_rs got %0d exp 1", ex_sel_rs); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_id(1, 1, 0, 1, 0, 0, 1, 1);
        step();
        set_id(1, 0, 0, 1, 1, 9, 1, 0);
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL zero_stall got %0b exp 0", stall); end
        step();
        tests++; if (ex_sel_rs !== 2'd0) begin fails++; $display("FAIL zero_sel_rs got %0d exp 0", ex_sel_rs); end
        tests++; if (ex_sel_rt !== 2'd0) begin fails++; $display("FAIL zero_sel_rt got %0d exp 0", ex_sel_rt); end
        set_id(1, 1, 0, 1, 0, 8, 1, 1);
        step();
        set_id(1, 1, 8, 1, 0, 10, 1, 0);
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL unused_stall got %0b exp 0", stall); end
        step();
        tests++; if (ex_sel_rt !== 2'd0) begin fails++; $display("FAIL unused_sel_rt got %0d exp 0", ex_sel_rt); end
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1, 1, 0, 1, 0, 5, 1, 1);
        step();
        set_id(1, 1, 5, 1, 1, 9, 1, 0);
        flush = 1;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall got %0b exp 0", stall); end
        step();
        flush = 0;
        tests++; if (ex_sel_rt !== 2'd0) begin fails++; $display("FAIL flush_sel_rt got %0d exp 0", ex_sel_rt); end
        tests++; if (stall_count !== 8'd0) begin fails++; $display("FAIL flush_count got %0d exp 0", stall_count); end
        set_id(1, 9, 5, 1, 1, 11, 1, 0);
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_after_stall got %0b exp 0", stall); end
        step();
        tests++; if (ex_sel_rs !== 2'd0) begin fails++; $display("FAIL flush_killed_rs got %0d exp 0", ex_sel_rs); end
        tests++; if (ex_sel_rt !== 2'd2) begin fails++; $display("FAIL flush_load_rt got %0d exp 2", ex_sel_rt); end
    endtask

    task automatic test_saturation_reset();
        int guard;
        do_reset();
        set_id(1, 5, 0, 1, 0, 5, 1, 1);
        for (int k = 0; k < 2 * (256 + 3) + 2; k++) step();
        tests++; if (stall_count !== 8'hFF) begin fails++; $display("FAIL sat_count got %0d exp 255", stall_count); end
        guard = 0;
        while (stall !== 1'b1 && guard < 4) begin step(); guard++; end
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sat_stall_seen got %0b exp 1", stall); end
        reset = 1;
        step();
        reset = 0;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL midrst_stall got %0b exp 0", stall); end
        tests++; if (ex_sel_rs !== 2'd0) begin fails++; $display("FAIL midrst_sel_rs got %0d exp 0", ex_sel_rs); end
        tests++; if (stall_count !== 8'd0) begin fails++; $display("FAIL midrst_count got %0d exp 0", stall_count); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_double_producer();
        test_zero_reg();
        test_flush();
        test_saturation_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the in-order integer pipeline.
- Tracks in-flight destination registers in an internal scoreboard and computes registered forwarding selects for both EX operands.
- Raises a load-use stall toward the ID stage and counts stall cycles.
- Sits beside the ID/EX pipeline register; its selects drive the EX operand muxes.

Parameters:
- REG_ADDR_W, 5: register address width.
- NUM_FWD, 3: number of forwarding buses after EX (bus k = result of the instruction k stages ahead of EX).
- SEL_W, $clog2(NUM_FWD+1): select width.
- LOAD_READY, 2: lowest bus index on which load data is valid.
- ZERO_REG, 1: register 0 is hardwired; it never matches and is never forwarded.
- CNT_W, 16: stall counter width.

Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-high.
- id_valid, in, 1: a valid instruction is in ID.
- id_rs, in, REG_ADDR_W: ID source operand A.
- id_rt, in, REG_ADDR_W: ID source operand B.
- id_uses_rs, in, 1: operand A is actually read.
- id_uses_rt, in, 1: operand B is actually read.
- id_dst, in, REG_ADDR_W: ID destination register.
- id_reg_write, in, 1: ID instruction writes id_dst.
- id_mem_read, in, 1: ID instruction is a load.
- flush, in, 1: kill the instruction moving ID->EX.
- stall, out, 1: hold PC and IF/ID; insert a bubble into EX.
- ex_sel_rs, out, SEL_W: EX operand A source (0 = register file, k = bus k).
- ex_sel_rt, out, SEL_W: EX operand B source.
- stall_count, out, CNT_W: saturating count of stall cycles.

Behaviour:
- Reset (synchronous, active-high):
  - all scoreboard entries invalid.
  - ex_sel_rs = ex_sel_rt = 0, stall_count = 0.
  - stall = 0, since the scoreboard is empty.
- Scoreboard: NUM_FWD entries; entry i = instruction currently i stages past EX entry (entry 0 = EX). Fields: valid, wr, dst, load.
- Match rule: entry i matches operand r when valid & wr & dst==r & uses_r & id_valid, and, if ZERO_REG, r != 0.
- Source select per operand:
  - Pick the smallest matching i (youngest producer wins).
  - Candidate select = i+1, because the producer is one stage further on when the consumer reaches EX.
  - No match gives 0.
- Hazard: the youngest match has load=1 and i+1 < LOAD_READY. Older matches are ignored once a younger one exists.
- stall = hazard(rs) | hazard(rt), masked by flush. It is combinational from the ID inputs and the current scoreboard.
- Each clock, priority is reset > flush > stall > normal.
  - All cases: entries shift, entry i+1 <= entry i, and the oldest entry is dropped.
  - flush or stall: entry 0 <= bubble (valid=0); ex_sel_* <= 0.
  - normal: entry 0 <= {id_valid, id_reg_write, id_dst, id_mem_read}; ex_sel_* <= candidate selects.
- Latency:
  - Selects are valid in the cycle after the instruction is accepted from ID, aligned with the instruction in EX.
  - A load-use stall lasts LOAD_READY-1-i cycles, where i is the load's entry index; default is 1 cycle.
- stall_count increments on each cycle with stall=1 and saturates at all-ones. reset clears it.
- Simultaneous events:
  - Both operands matching the same producer get identical selects.
  - A stall with a concurrent flush produces no stall and no count increment.
- Reset mid-stall clears the scoreboard; stall deasserts in the following cycle.

Decomposition:
- Shared package `fwd_pkg`:
  - constant SRC_REGFILE = 0.
  - sb_entry_t struct {valid, wr, dst, load}.
  - a function computing SEL_W.
- Sub-module `fwd_operand_select`:
  - one operand's priority encoder over the scoreboard.
  - outputs candidate select and hazard.
  - instantiated twice (rs, rt).

Test Plan:
- Back-to-back ALU ops: add r3 then sub using rs=r3 -> ex_sel_rs=1, stall=0. A second consumer two cycles later -> sel=2.
- Load-use: lw r5 then add rt=r5 -> stall=1 for exactly 1 cycle, bubble in EX, ex_sel_rt=2 on the following accept, stall_count=1.
- Double producer: writes to r4 at entries 0 and 1, consumer reads r4 -> ex_sel_rs=1 (youngest wins).
- Zero register: producer writes r0, consumer reads r0 -> selects 0, no stall. With id_uses_rt=0 and an rt match -> ex_sel_rt=0.
- Flush during a load-use hazard -> stall=0, entry 0 bubble, selects 0, stall_count unchanged.
- Saturation/reset: force 2^CNT_W+3 stall cycles -> stall_count = all-ones. Assert reset mid-stall -> next cycle stall=0, selects 0, count 0.
